// File: rtl/ifetch_unit_if.sv
// ifetch_unit_if: fetch request, program-memory read bus and instruction
// handshake of the instruction fetch unit.
// master = the fetch unit, slave = its environment (PC stage, memory, decode).
// Optional macro IFETCH_TIMEOUT_EN adds the instr_err signal.
interface ifetch_unit_if #(
  parameter int DATA_WIDTH = 16,
  parameter int PC_WIDTH   = 16
);
  // fetch request from the PC stage
  logic                  fetch_req;
  logic [PC_WIDTH-1:0]   fetch_pc;
  logic                  flush;
  logic                  fetch_busy;
  // word-addressed program memory read bus
  logic                  mem_rd;
  logic [PC_WIDTH:0]     mem_addr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_rvalid;
  // instruction pair handshake towards decode
  logic                  instr_valid;
  logic                  instr_ready;
  logic [DATA_WIDTH-1:0] opcode;
  logic [DATA_WIDTH-1:0] operand;
`ifdef IFETCH_TIMEOUT_EN
  logic                  instr_err;
`endif

  modport master (
    input  fetch_req, fetch_pc, flush, mem_rdata, mem_rvalid, instr_ready,
`ifdef IFETCH_TIMEOUT_EN
    output instr_err,
`endif
    output fetch_busy, mem_rd, mem_addr, instr_valid, opcode, operand
  );

  modport slave (
    output fetch_req, fetch_pc, flush, mem_rdata, mem_rvalid, instr_ready,
`ifdef IFETCH_TIMEOUT_EN
    input  instr_err,
`endif
    input  fetch_busy, mem_rd, mem_addr, instr_valid, opcode, operand
  );
endinterface

// File: rtl/ifetch_unit.sv
// ifetch_unit: reads the two-word instruction (opcode at {pc,0}, operand at
// {pc,1}) from program memory over a single-outstanding read bus and holds
// the pair for decode under a valid/ready handshake. Flush aborts an
// in-flight fetch, draining a read that is already on the bus.
// Optional macro IFETCH_TIMEOUT_EN: read-response timeout after
// TIMEOUT_CYCLES wait cycles, producing a zeroed pair flagged by instr_err.
module ifetch_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int PC_WIDTH   = 16
`ifdef IFETCH_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 15
`endif
) (
  input  logic          clk,
  input  logic          reset,
  ifetch_unit_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, ISSUE_OP, WAIT_OP, ISSUE_ARG, WAIT_ARG, HOLD, DRAIN
  } state_t;

  state_t                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [DATA_WIDTH-1:0] opcode_q, opcode_d;
  logic [DATA_WIDTH-1:0] operand_q, operand_d;

`ifdef IFETCH_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES < 16) ? 4 : $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             timeout;

  // last permitted wait cycle passed without a response
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) && !bus.mem_rvalid;
`endif

  // next-state and datapath: flush wins over every other transition
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
`ifdef IFETCH_TIMEOUT_EN
    err_d     = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.fetch_req && !bus.flush) begin
          pc_d    = bus.fetch_pc;
          state_d = ISSUE_OP;
        end
      end
      ISSUE_OP:  state_d = bus.flush ? IDLE : WAIT_OP;
      ISSUE_ARG: state_d = bus.flush ? IDLE : WAIT_ARG;
      WAIT_OP: begin
        // a response arriving with the flush completes the read: nothing to drain
        if (bus.flush) begin
          state_d = bus.mem_rvalid ? IDLE : DRAIN;
        end else if (bus.mem_rvalid) begin
          opcode_d = bus.mem_rdata;
          state_d  = ISSUE_ARG;
        end
`ifdef IFETCH_TIMEOUT_EN
        else if (timeout) begin
          opcode_d  = '0;
          operand_d = '0;
          err_d     = 1'b1;
          state_d   = HOLD;
        end
`endif
      end
      WAIT_ARG: begin
        if (bus.flush) begin
          state_d = bus.mem_rvalid ? IDLE : DRAIN;
        end else if (bus.mem_rvalid) begin
          operand_d = bus.mem_rdata;
          state_d   = HOLD;
        end
`ifdef IFETCH_TIMEOUT_EN
        else if (timeout) begin
          opcode_d  = '0;
          operand_d = '0;
          err_d     = 1'b1;
          state_d   = HOLD;
        end
`endif
      end
      HOLD: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else if (bus.instr_ready) begin
`ifdef IFETCH_TIMEOUT_EN
          err_d = 1'b0;
`endif
          // handover: the next request is taken in the same cycle
          if (bus.fetch_req) begin
            pc_d    = bus.fetch_pc;
            state_d = ISSUE_OP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DRAIN: begin
        if (bus.mem_rvalid) begin
          state_d = IDLE;
        end
`ifdef IFETCH_TIMEOUT_EN
        else if (timeout) begin
          state_d = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
`ifdef IFETCH_TIMEOUT_EN
    if (bus.flush) begin
      err_d = 1'b0;
    end
    // wait counter restarts on every state entry
    cnt_d = '0;
    if ((state_q == WAIT_OP || state_q == WAIT_ARG || state_q == DRAIN) &&
        (state_d == state_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
`endif
  end

  // state and datapath registers; reset abandons any read without draining
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      opcode_q  <= '0;
      operand_q <= '0;
`ifdef IFETCH_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
`ifdef IFETCH_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  // read strobe is cut by flush in the same cycle so no read escapes
  assign bus.mem_rd      = ((state_q == ISSUE_OP) || (state_q == ISSUE_ARG)) && !bus.flush;
  assign bus.mem_addr    = (state_q == ISSUE_OP)  ? {pc_q, 1'b0} :
                           (state_q == ISSUE_ARG) ? {pc_q, 1'b1} : '0;
  assign bus.fetch_busy  = (state_q != IDLE);
  assign bus.instr_valid = (state_q == HOLD);
  assign bus.opcode      = opcode_q;
  assign bus.operand     = operand_q;
`ifdef IFETCH_TIMEOUT_EN
  assign bus.instr_err   = err_q;
`endif

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch unit for the 16-bit processor: the read side of the program-counter interface. It takes the PC value and reads the two-word instruction (opcode word, then operand word) from word-addressed program memory over a single-outstanding read bus. It presents the opcode and operand pair to the decode/ALU/PC stage with a valid/ready handshake. Flush discards any in-flight fetch when a branch is taken.

## Interface
- DATA_WIDTH, 16, instruction word width (opcode and operand)
- PC_WIDTH, 16, program counter width
- TIMEOUT_CYCLES, 15, read-response timeout in cycles; used only with IFETCH_TIMEOUT_EN
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- fetch_req  in  1  request to fetch the instruction at fetch_pc
- fetch_pc  in  PC_WIDTH  instruction index; sampled only when the request is accepted
- flush  in  1  abort current fetch and drop any held instruction
- fetch_busy  out  1  high whenever state != IDLE
- mem_rd  out  1  one-cycle read strobe
- mem_addr  out  PC_WIDTH+1  word address, valid while mem_rd=1
- mem_rdata  in  DATA_WIDTH  read data
- mem_rvalid  in  1  read data valid; latency ≥1 cycle after mem_rd
- instr_valid  out  1  opcode/operand pair available
- instr_ready  in  1  consumer accepts the pair
- opcode  out  DATA_WIDTH  fetched opcode word
- operand  out  DATA_WIDTH  fetched operand word
- instr_err  out  1  pair produced by timeout; exists only with IFETCH_TIMEOUT_EN

## Operation
- States: IDLE, ISSUE_OP, WAIT_OP, ISSUE_ARG, WAIT_ARG, HOLD, DRAIN.
- Captured PC register pc_q. Opcode address = {pc_q,1'b0}. Operand address = {pc_q,1'b1}. No truncation.
- IDLE: fetch_req=1 and flush=0 → capture fetch_pc, go to ISSUE_OP.
- ISSUE_OP: mem_rd=1, mem_addr=opcode address, go to WAIT_OP. ISSUE_ARG behaves the same with the operand address, then goes to WAIT_ARG.
- WAIT_OP: mem_rvalid → register opcode, go to ISSUE_ARG.
- WAIT_ARG: mem_rvalid → register operand, go to HOLD.
- HOLD: instr_valid=1; opcode/operand stable.
  - instr_ready=1 → IDLE.
  - instr_ready=1 and fetch_req=1 in the same cycle → accept the new PC and go directly to ISSUE_OP.
- mem_rvalid outside WAIT_*/DRAIN is ignored.
- fetch_req while busy (other than the HOLD handover) is ignored, not queued.
- flush has priority over everything except reset:
  - ISSUE_*: mem_rd suppressed (mem_rd = issue state & ~flush), go to IDLE.
  - WAIT_*: go to DRAIN.
  - DRAIN: wait for mem_rvalid, discard the data, go to IDLE.
  - HOLD: go to IDLE. If instr_ready=1 in the same cycle, the transfer counts as completed.
  - IDLE/DRAIN: fetch_req with flush is ignored.
- Reset: state=IDLE, mem_rd=0, mem_addr=0, instr_valid=0, opcode=0, operand=0, fetch_busy=0, instr_err=0, pc_q=0. Reset mid-read abandons the read with no drain; memory is reset together with this block.

## Timing
- Zero-wait memory (rvalid one cycle after mem_rd), request accepted at cycle 0:
  - mem_rd (opcode) at cycle 1
  - rvalid at cycle 2
  - mem_rd (operand) at cycle 3
  - rvalid at cycle 4
  - instr_valid at cycle 5
- Each extra memory wait cycle adds one cycle.
- Back-to-back fetches with instr_ready held high: one instruction per 5 cycles.
- mem_rd is never high on two consecutive cycles. At most one read is outstanding.
- opcode and operand change only on WAIT_* capture. They stay stable while instr_valid=1 and instr_ready=0.

## Configuration
- IFETCH_TIMEOUT_EN defined:
  - A 4-bit-or-wider cycle counter runs in WAIT_OP, WAIT_ARG and DRAIN, and clears on state entry.
  - After TIMEOUT_CYCLES cycles without mem_rvalid:
    - WAIT_* → HOLD with opcode=0, operand=0, instr_err=1.
    - DRAIN → IDLE.
  - instr_err clears when a HOLD handshake completes or on flush.
  - The memory contract forbids responses after a timeout.
- IFETCH_TIMEOUT_EN undefined: no counter and no instr_err port. WAIT states wait indefinitely.

## Test plan
- Zero-wait fetch, fetch_pc=0x0003, memory[6]=0x7100, memory[7]=0x0042 → mem_addr 6 then 7; instr_valid at cycle 5 with opcode=0x7100, operand=0x0042.
- Backpressure: instr_ready low for 4 cycles → instr_valid stays 1 and outputs hold constant; HOLD with fetch_req=1 and instr_ready=1 → next mem_rd on the following cycle.
- Flush in WAIT_OP with 3-cycle memory latency → block enters DRAIN, swallows the late response, returns to IDLE; a new fetch of pc=0x0010 returns memory[0x20]/[0x21] uncorrupted.
- Flush in ISSUE_ARG → mem_rd stays 0 that cycle, state goes to IDLE, instr_valid never asserts.
- fetch_pc=0xFFFF → mem_addr 0x1FFFE then 0x1FFFF, with no wrap to 0.
- With IFETCH_TIMEOUT_EN and mem_rvalid held 0 → instr_valid after 15 wait cycles with instr_err=1, opcode=0, operand=0; reset mid-WAIT_ARG → all outputs 0 next cycle.
